// File: rtl/rvfi_seq_pkg.sv
// Shared types and helpers for the formal-run sequencer.
package rvfi_seq_pkg;

    localparam int MAX_NRET = 8;
    localparam int PC_W     = $clog2(MAX_NRET + 1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_WARM  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [MAX_NRET-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_NRET; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rvfi_sat_counter.sv
// Saturating accumulator: clears on clr, otherwise adds inc and clamps at all-ones.
module rvfi_sat_counter #(
    parameter int W = 16
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         clr_i,
    input  logic [W-1:0] inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W:0]   sum;

    // Carry-out of the widened sum means the add would wrap, so clamp instead.
    assign sum = {1'b0, q_q} + {1'b0, inc_i};

    always_ff @(posedge clock_i) begin
        if (reset_i || clr_i) begin
            q_q <= '0;
        end else if (sum[W]) begin
            q_q <= '1;
        end else begin
            q_q <= sum[W-1:0];
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Sequences one formal check run (DUT reset, warm-up, check window, done) and
// tracks retirement counts and retire stalls.
//   state   | meaning
//   S_RESET | dut_reset held for RESET_CYCLES
//   S_WARM  | warm-up, SKIP_CYCLES long
//   S_CHECK | check asserted for CHECK_CYCLES
//   S_DONE  | run complete, terminal until reset
module rvfi_check_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int NRET         = 1,
    parameter int RESET_CYCLES = 1,
    parameter int SKIP_CYCLES  = 10,
    parameter int CHECK_CYCLES = 1,
    parameter int STALL_LIMIT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NRET-1:0]  rvfi_valid,
    output logic             dut_reset,
    output logic             check,
    output logic             done,
    output logic             stall,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    if (RESET_CYCLES < 1) begin : g_err_reset_cycles
        $error("RESET_CYCLES must be >= 1");
    end
    if (CHECK_CYCLES < 1) begin : g_err_check_cycles
        $error("CHECK_CYCLES must be >= 1");
    end
    if (NRET < 1 || NRET > MAX_NRET) begin : g_err_nret
        $error("NRET must be in 1..8");
    end
    if (CNT_W < PC_W) begin : g_err_cnt_w
        $error("CNT_W too narrow for a per-cycle retire count");
    end

    localparam logic [31:0] RST_LAST   = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] SKIP_LAST  = 32'(SKIP_CYCLES - 1);
    localparam logic [31:0] CHECK_LAST = 32'(CHECK_CYCLES - 1);
    localparam logic [31:0] STALL_LIM  = 32'(STALL_LIMIT);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic             dut_reset_q, check_q, done_q, stall_q;

    logic             active;
    logic             counting;
    logic             any_valid;
    logic             stall_set;
    logic [CNT_W-1:0] cycle_inc;
    logic [CNT_W-1:0] retire_inc;
    logic [CNT_W-1:0] stall_inc;
    logic [CNT_W-1:0] stall_cnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: if (32'(phase_q) == RST_LAST) begin
                state_d = (SKIP_CYCLES == 0) ? S_CHECK : S_WARM;
            end
            S_WARM:  if (32'(phase_q) == SKIP_LAST)  state_d = S_CHECK;
            S_CHECK: if (32'(phase_q) == CHECK_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RESET;
        endcase

        // Phase restarts on every transition and parks at zero once done.
        if (state_d != state_q || state_q == S_DONE) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + CNT_W'(1);
        end
    end

    assign active    = (state_q != S_RESET);
    assign counting  = (state_q == S_WARM) || (state_q == S_CHECK);
    assign any_valid = |rvfi_valid;

    // A retirement in the limit cycle clears the counter and suppresses the flag.
    assign stall_set = (STALL_LIMIT != 0) && (32'(stall_cnt) >= STALL_LIM)
                       && !(counting && any_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_RESET;
            phase_q     <= '0;
            dut_reset_q <= 1'b1;
            check_q     <= 1'b0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            dut_reset_q <= (state_d == S_RESET);
            check_q     <= (state_d == S_CHECK);
            done_q      <= (state_d == S_DONE);
            stall_q     <= stall_q | stall_set;
        end
    end

    assign cycle_inc  = {{(CNT_W-1){1'b0}}, active};
    assign retire_inc = active ? CNT_W'(popcount(MAX_NRET'(rvfi_valid))) : '0;
    assign stall_inc  = {{(CNT_W-1){1'b0}}, counting};

    rvfi_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock_i (clock),
        .reset_i (reset),
        .clr_i   (!active),
        .inc_i   (cycle_inc),
        .q_o     (cycle_count)
    );

    rvfi_sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clock_i (clock),
        .reset_i (reset),
        .clr_i   (!active),
        .inc_i   (retire_inc),
        .q_o     (retire_count)
    );

    rvfi_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock_i (clock),
        .reset_i (reset),
        .clr_i   (!active || (counting && any_valid)),
        .inc_i   (stall_inc),
        .q_o     (stall_cnt)
    );

    assign dut_reset = dut_reset_q;
    assign check     = check_q;
    assign done      = done_q;
    assign stall     = stall_q;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Directed bench: several parameterisations share clock/reset, each driven and checked per cycle.
module tb_rvfi_check_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        v_def, v_s0, v_stl;
    logic [1:0]  v_n2, v_sat;

    logic        dr_def, ck_def, dn_def, st_def;
    logic [15:0] cc_def, rc_def;
    logic        dr_s0, ck_s0, dn_s0, st_s0;
    logic [15:0] cc_s0, rc_s0;
    logic        dr_n2, ck_n2, dn_n2, st_n2;
    logic [15:0] cc_n2, rc_n2;
    logic        dr_sat, ck_sat, dn_sat, st_sat;
    logic [3:0]  cc_sat, rc_sat;
    logic        dr_stl, ck_stl, dn_stl, st_stl;
    logic [15:0] cc_stl, rc_stl;

    int n_checks = 0;
    int n_fail   = 0;

    rvfi_check_sequencer u_def (
        .clock(clock), .reset(reset), .rvfi_valid(v_def),
        .dut_reset(dr_def), .check(ck_def), .done(dn_def), .stall(st_def),
        .cycle_count(cc_def), .retire_count(rc_def)
    );

    rvfi_check_sequencer #(.SKIP_CYCLES(0), .CHECK_CYCLES(3)) u_s0 (
        .clock(clock), .reset(reset), .rvfi_valid(v_s0),
        .dut_reset(dr_s0), .check(ck_s0), .done(dn_s0), .stall(st_s0),
        .cycle_count(cc_s0), .retire_count(rc_s0)
    );

    rvfi_check_sequencer #(.NRET(2)) u_n2 (
        .clock(clock), .reset(reset), .rvfi_valid(v_n2),
        .dut_reset(dr_n2), .check(ck_n2), .done(dn_n2), .stall(st_n2),
        .cycle_count(cc_n2), .retire_count(rc_n2)
    );

    rvfi_check_sequencer #(.NRET(2), .CNT_W(4)) u_sat (
        .clock(clock), .reset(reset), .rvfi_valid(v_sat),
        .dut_reset(dr_sat), .check(ck_sat), .done(dn_sat), .stall(st_sat),
        .cycle_count(cc_sat), .retire_count(rc_sat)
    );

    rvfi_check_sequencer #(.STALL_LIMIT(4), .CHECK_CYCLES(20)) u_stl (
        .clock(clock), .reset(reset), .rvfi_valid(v_stl),
        .dut_reset(dr_stl), .check(ck_stl), .done(dn_stl), .stall(st_stl),
        .cycle_count(cc_stl), .retire_count(rc_stl)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // One cycle of dut_reset after reset drops, with garbage on every rvfi_valid.
    task automatic start_run();
        @(posedge clock); #1;
        reset = 1'b1;
        v_def = 1'b1; v_s0 = 1'b1; v_stl = 1'b1; v_n2 = 2'b11; v_sat = 2'b11;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk_eq("rst_dut_reset", 32'(dr_def), 32'd1);
        chk_eq("rst_check",     32'(ck_def), 32'd0);
        chk_eq("rst_done",      32'(dn_def), 32'd0);
        chk_eq("rst_stall",     32'(st_def), 32'd0);
        chk_eq("rst_cycle_cnt", 32'(cc_def), 32'd0);
        chk_eq("rst_retire",    32'(rc_n2),  32'd0);
        @(posedge clock); #1;
    endtask

    task automatic def_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            v_def = 1'b1;
            @(negedge clock);
            chk_eq("def_dut_reset", 32'(dr_def), 32'd0);
            chk_eq("def_check",     32'(ck_def), 32'(k == 10));
            chk_eq("def_done",      32'(dn_def), 32'(k >= 11));
            chk_eq("def_stall",     32'(st_def), 32'd0);
            chk_eq("def_cycle_cnt", 32'(cc_def), 32'(k));
            chk_eq("def_retire",    32'(rc_def), 32'(k));
            if (k < n - 1) begin
                @(posedge clock); #1;
            end
        end
    endtask

    int acc_n2;

    initial begin
        v_def = 1'b0; v_s0 = 1'b0; v_stl = 1'b0; v_n2 = 2'b00; v_sat = 2'b00;

        // Run 1: all parameterisations together.
        start_run();
        acc_n2 = 0;
        for (int k = 0; k <= 20; k++) begin
            v_def = 1'b1;
            v_s0  = 1'b1;
            v_n2  = (k < 5) ? 2'b11 : (k < 8) ? 2'b01 : 2'b00;
            v_sat = 2'b11;
            v_stl = 1'b0;
            @(negedge clock);
            chk_eq("def_check",     32'(ck_def), 32'(k == 10));
            chk_eq("def_done",      32'(dn_def), 32'(k >= 11));
            chk_eq("def_dut_reset", 32'(dr_def), 32'd0);
            chk_eq("def_stall",     32'(st_def), 32'd0);
            chk_eq("def_cycle_cnt", 32'(cc_def), 32'(k));
            chk_eq("def_retire",    32'(rc_def), 32'(k));
            chk_eq("s0_check",      32'(ck_s0),  32'(k < 3));
            chk_eq("s0_done",       32'(dn_s0),  32'(k >= 3));
            chk_eq("n2_retire",     32'(rc_n2),  32'(acc_n2));
            chk_eq("sat_cycle_cnt", 32'(cc_sat), (k > 15) ? 32'd15 : 32'(k));
            chk_eq("sat_retire",    32'(rc_sat), (2 * k > 15) ? 32'd15 : 32'(2 * k));
            chk_eq("stl_stall",     32'(st_stl), 32'(k >= 5));
            acc_n2 = acc_n2 + ((k < 5) ? 2 : (k < 8) ? 1 : 0);
            @(posedge clock); #1;
        end
        chk_eq("n2_retire_total", 32'(rc_n2), 32'd13);

        // Stall prevention: one retirement at cycle 3, then at the limit cycle 4.
        for (int r = 3; r <= 4; r++) begin
            start_run();
            for (int k = 0; k <= 11; k++) begin
                v_stl = (k == r);
                @(negedge clock);
                chk_eq("stl_retire_at", 32'(st_stl), 32'(k >= r + 6));
                @(posedge clock); #1;
            end
        end

        // Reset mid-CHECK, then replay.
        start_run();
        def_cycles(11);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk_eq("mid_dut_reset", 32'(dr_def), 32'd1);
        chk_eq("mid_check",     32'(ck_def), 32'd0);
        chk_eq("mid_done",      32'(dn_def), 32'd0);
        chk_eq("mid_stall",     32'(st_def), 32'd0);
        chk_eq("mid_cycle_cnt", 32'(cc_def), 32'd0);
        chk_eq("mid_retire",    32'(rc_def), 32'd0);
        @(posedge clock); #1;
        def_cycles(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
